// File: rtl/key_debounce_multi_pkg.sv
// Shared constants for the multi-key debouncer.
// Key polarity, LED mode codes and 50 MHz defaults.
package key_debounce_multi_pkg;
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;
  localparam logic LED_LEVEL    = 1'b0;
  localparam logic LED_TOGGLE   = 1'b1;

  localparam int CNT_W  = 20;
  localparam int LONG_W = 26;

  localparam logic [CNT_W-1:0]  DEF_CNT_MAX  = 20'd999_999;
  localparam logic [LONG_W-1:0] DEF_LONG_MAX = 26'd49_999_999;
endpackage

// File: rtl/key_debounce_multi_ch.sv
// One key channel: synchroniser, debounce filter,
// long-press counter and LED register.
module key_debounce_multi_ch
  import key_debounce_multi_pkg::*;
#(
  parameter logic [CNT_W-1:0]  CNT_MAX  = DEF_CNT_MAX,
  parameter logic [LONG_W-1:0] LONG_MAX = DEF_LONG_MAX,
  parameter logic              LED_MODE = LED_LEVEL
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic led_out
);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_level;
  logic [CNT_W-1:0]  r_cnt;
  logic [LONG_W-1:0] r_lcnt;
  logic              r_press;
  logic              r_rel;
  logic              r_long;
  logic              r_led;

  logic              w_diff;
  logic              w_flip;
  logic              w_level_nxt;
  logic [LONG_W-1:0] w_lcnt_nxt;

  assign w_diff      = (r_sync2 != r_level);
  assign w_flip      = w_diff && (r_cnt == CNT_MAX);
  assign w_level_nxt = w_flip ? r_sync2 : r_level;

  // press cycle counts as the first held cycle
  always_comb begin
    w_lcnt_nxt = r_lcnt;
    if (r_level == KEY_RELEASED)
      w_lcnt_nxt = '0;
    else if (r_press)
      w_lcnt_nxt = LONG_W'(1);
    else if (r_lcnt != LONG_MAX)
      w_lcnt_nxt = r_lcnt + LONG_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_sync1 <= KEY_RELEASED;
      r_sync2 <= KEY_RELEASED;
      r_level <= KEY_RELEASED;
      r_cnt   <= '0;
      r_lcnt  <= '0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_long  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      if (!w_diff || w_flip)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
      r_press <= w_flip && (r_sync2 == KEY_PRESSED);
      r_rel   <= w_flip && (r_sync2 == KEY_RELEASED);
      r_lcnt  <= w_lcnt_nxt;
      r_long  <= (w_lcnt_nxt == LONG_MAX)
              && (r_lcnt != LONG_MAX);
      if (LED_MODE == LED_TOGGLE)
        r_led <= r_led ^ (w_flip && (r_sync2 == KEY_PRESSED));
      else
        r_led <= ~w_level_nxt;
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_rel;
  assign key_long    = r_long;
  assign led_out     = r_led;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer: KEY_NUM independent channels
// with level, press/release/long pulses and LEDs.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int                KEY_NUM  = 4,
  parameter logic [CNT_W-1:0]  CNT_MAX  = DEF_CNT_MAX,
  parameter logic [LONG_W-1:0] LONG_MAX = DEF_LONG_MAX,
  parameter logic              LED_MODE = LED_LEVEL
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] led_out
);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce_multi_ch #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX),
      .LED_MODE (LED_MODE)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g]),
      .led_out     (led_out[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi, level-mode
// and toggle-mode instances driven from the same pins.
module tb_key_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;

  logic [3:0] lv0, pr0, rl0, lg0, ld0;
  logic [3:0] lv1, pr1, rl1, lg1, ld1;

  int total;
  int bad;

  key_debounce_multi #(
    .KEY_NUM(4), .CNT_MAX(20'd24),
    .LONG_MAX(26'd99), .LED_MODE(1'b0)
  ) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .key_in(key_in), .key_level(lv0),
    .key_press(pr0), .key_release(rl0),
    .key_long(lg0), .led_out(ld0)
  );

  key_debounce_multi #(
    .KEY_NUM(4), .CNT_MAX(20'd24),
    .LONG_MAX(26'd99), .LED_MODE(1'b1)
  ) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .key_in(key_in), .key_level(lv1),
    .key_press(pr1), .key_release(rl1),
    .key_long(lg1), .led_out(ld1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int np;
    rst_n  = 1'b0;
    key_in = 4'hF;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (lv0 !== 4'hF) begin
      bad++;
      $display("FAIL reset_level got=%h exp=F", lv0);
    end
    total++;
    if (ld0 !== 4'h0 || ld1 !== 4'h0) begin
      bad++;
      $display("FAIL reset_led got=%h/%h exp=0/0", ld0, ld1);
    end
    np = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      np += int'($countones({pr0, rl0, lg0, pr1, rl1, lg1}));
    end
    total++;
    if (np !== 0) begin
      bad++;
      $display("FAIL reset_idle_pulses got=%0d exp=0", np);
    end
  endtask

  task automatic test_clean_press();
    int eb;
    tick();
    key_in[0] = 1'b0;
    eb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pr0[0] !== (i == 27)) eb++;
      if (lv0[0] !== (i < 27)) eb++;
      if (ld0[0] !== (i >= 27)) eb++;
    end
    total++;
    if (eb !== 0) begin
      bad++;
      $display("FAIL clean_press errs got=%0d exp=0", eb);
    end
    tick();
    key_in[0] = 1'b1;
    eb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rl0[0] !== (i == 27)) eb++;
      if (pr0[0] !== 1'b0) eb++;
      if (lv0[0] !== (i >= 27)) eb++;
    end
    total++;
    if (eb !== 0) begin
      bad++;
      $display("FAIL clean_release errs got=%0d exp=0", eb);
    end
  endtask

  task automatic bounce(input logic start);
    logic b;
    int   run;
    b   = start;
    run = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (run >= 8 || $urandom_range(0, 1) == 1) begin
        b   = ~b;
        run = 0;
      end else begin
        run++;
      end
      key_in[1] = b;
    end
  endtask

  task automatic test_bounce();
    int np, nr, nb;
    nb = 0;
    fork
      bounce(1'b1);
      for (int i = 0; i < 50; i++) begin
        tick();
        nb += int'(pr0[1]) + int'(rl0[1]);
      end
    join
    key_in[1] = 1'b0;
    np = 0;
    nr = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      np += int'(pr0[1]);
      nr += int'(rl0[1]);
    end
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL bounce_press_quiet got=%0d exp=0", nb);
    end
    total++;
    if (np !== 1 || nr !== 0) begin
      bad++;
      $display("FAIL bounce_press got=%0d/%0d exp=1/0", np, nr);
    end
    nb = 0;
    fork
      bounce(1'b0);
      for (int i = 0; i < 50; i++) begin
        tick();
        nb += int'(pr0[1]) + int'(rl0[1]);
      end
    join
    key_in[1] = 1'b1;
    np = 0;
    nr = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      np += int'(pr0[1]);
      nr += int'(rl0[1]);
    end
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL bounce_release_quiet got=%0d exp=0", nb);
    end
    total++;
    if (np !== 0 || nr !== 1) begin
      bad++;
      $display("FAIL bounce_release got=%0d/%0d exp=0/1", np, nr);
    end
  endtask

  task automatic test_long();
    bit found;
    int eb, nl;
    tick();
    key_in[2] = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pr0[2] === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL long_press_seen got=0 exp=1");
    end
    eb = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (lg0[2] !== (k == 99)) eb++;
    end
    total++;
    if (eb !== 0) begin
      bad++;
      $display("FAIL long_timing errs got=%0d exp=0", eb);
    end
    key_in[2] = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    key_in[2] = 1'b0;
    nl = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      nl += int'(lg0[2]);
    end
    key_in[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      nl += int'(lg0[2]);
    end
    total++;
    if (nl !== 0) begin
      bad++;
      $display("FAIL long_short_hold got=%0d exp=0", nl);
    end
  endtask

  task automatic test_led_toggle();
    logic [2:0] exp_led;
    bit found;
    int nr;
    exp_led = 3'b101;
    for (int p = 0; p < 3; p++) begin
      tick();
      key_in[3] = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        tick();
        if (pr1[3] === 1'b1) found = 1;
      end
      total++;
      if (!found || ld1[3] !== exp_led[2-p]) begin
        bad++;
        $display("FAIL led_toggle_%0d got=%b exp=%b",
                 p, ld1[3], exp_led[2-p]);
      end
      key_in[3] = 1'b1;
      for (int i = 0; i < 40; i++) tick();
    end
    key_in[3] = 1'b0;
    for (int i = 0; i < 35; i++) tick();
    total++;
    if (lv1[3] !== 1'b0 || ld0[3] !== 1'b1) begin
      bad++;
      $display("FAIL midpress_held got=%b/%b exp=0/1",
               lv1[3], ld0[3]);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (lv0 !== 4'hF || lv1 !== 4'hF) begin
      bad++;
      $display("FAIL midreset_level got=%h/%h exp=F/F", lv0, lv1);
    end
    total++;
    if (ld0 !== 4'h0 || ld1 !== 4'h0) begin
      bad++;
      $display("FAIL midreset_led got=%h/%h exp=0/0", ld0, ld1);
    end
    rst_n  = 1'b1;
    key_in = 4'hF;
    nr = int'($countones({rl0, rl1}));
    for (int i = 0; i < 40; i++) begin
      tick();
      nr += int'($countones({rl0, rl1}));
    end
    total++;
    if (nr !== 0) begin
      bad++;
      $display("FAIL midreset_norelease got=%0d exp=0", nr);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    tick();
    key_in = 4'b0110;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pr0 !== 4'h0) found = 1;
    end
    total++;
    if (!found || pr0 !== 4'b1001) begin
      bad++;
      $display("FAIL simul_press got=%b exp=1001", pr0);
    end
    key_in = 4'hF;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (rl0 !== 4'h0) found = 1;
    end
    total++;
    if (!found || rl0 !== 4'b1001) begin
      bad++;
      $display("FAIL simul_release got=%b exp=1001", rl0);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    key_in = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long();
    test_led_toggle();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
